// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and count limits for the stopwatch
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [7:0] MIN_MAX = 8'd99;

endpackage

// File: rtl/rise_edge_det.sv
// rtl/rise_edge_det.sv - single-flop rising-edge detector for debounced levels
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/stopwatch_seconds_ctrl.sv
// rtl/stopwatch_seconds_ctrl.sv - run control FSM, 1 s prescaler and 0-59 seconds counter
import stopwatch_pkg::*;

module stopwatch_seconds_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [5:0] seconds,
  output logic       minute_en,
  output logic       minutes_clr,
  output logic       running
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] prescaler;
  logic [5:0]    sec_q;
  logic          clr_q;
  logic          start_e;
  logic          stop_e;
  logic          clear_e;
  logic          sec_tick;
  logic          tick_go;

  rise_edge_det u_start_det (.clk(clk), .rst_n(rst_n), .level(start), .rise(start_e));
  rise_edge_det u_stop_det  (.clk(clk), .rst_n(rst_n), .level(stop),  .rise(stop_e));
  rise_edge_det u_clear_det (.clk(clk), .rst_n(rst_n), .level(clear), .rise(clear_e));

  assign sec_tick = (state == RUN) && (prescaler == PRE_LAST);
  // A clear or stop landing on the tick cycle swallows it; a stopped tick re-fires on resume.
  assign tick_go  = sec_tick && !clear_e && !stop_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear_e) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_e && !stop_e) state_nxt = RUN;
        RUN:     if (stop_e)             state_nxt = PAUSE;
        PAUSE:   if (start_e && !stop_e) state_nxt = RUN;
        default:                         state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    running   = (state == RUN);
    minute_en = tick_go && (sec_q == SEC_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      sec_q     <= 6'd0;
      clr_q     <= 1'b0;
    end else begin
      clr_q <= clear_e;
      if (clear_e || (state != RUN && state != PAUSE)) begin
        prescaler <= '0;
        sec_q     <= 6'd0;
      end else if (state == RUN && !stop_e) begin
        if (sec_tick) begin
          prescaler <= '0;
          sec_q     <= (sec_q == SEC_MAX) ? 6'd0 : sec_q + 6'd1;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

  assign seconds     = sec_q;
  assign minutes_clr = clr_q;

endmodule

// File: tb/tb_stopwatch_seconds_ctrl.sv
// tb/tb_stopwatch_seconds_ctrl.sv - directed bench with a cycle-level stopwatch model
module tb_stopwatch_seconds_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       clear;
  logic [5:0] seconds;
  logic       minute_en;
  logic       minutes_clr;
  logic       running;

  int errors = 0;
  int checks = 0;

  stopwatch_seconds_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .seconds(seconds), .minute_en(minute_en), .minutes_clr(minutes_clr), .running(running)
  );

  always #5 clk = ~clk;

  // Model: run flag, cycles into the current second, elapsed seconds mod 60.
  bit m_run = 0;
  int m_ct  = 0;
  int m_sec = 0;
  bit m_clr = 0;
  bit ps = 0, pp = 0, pc = 0;
  bit se, pe, ce;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_ct = 0; m_sec = 0; m_clr = 0;
      ps = 0; pp = 0; pc = 0;
    end else begin
      se = start && !ps;
      pe = stop && !pp;
      ce = clear && !pc;
      m_clr = ce;
      if (ce) begin
        m_run = 0; m_ct = 0; m_sec = 0;
      end else if (m_run) begin
        if (pe) m_run = 0;
        else if (m_ct == TD - 1) begin
          m_ct = 0;
          m_sec = (m_sec + 1) % 60;
        end else m_ct = m_ct + 1;
      end else if (se && !pe) begin
        m_run = 1;
      end
      ps = start; pp = stop; pc = clear;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit exp_me;
    exp_me = m_run && (m_ct == TD - 1) && (m_sec == 59) && !(clear && !pc) && !(stop && !pp);
    chk("model_seconds", 32'(seconds), 32'(m_sec));
    chk("model_running", 32'(running), 32'(m_run));
    chk("model_minute_en", 32'(minute_en), 32'(exp_me));
    chk("model_minutes_clr", 32'(minutes_clr), 32'(m_clr));
  endtask

  // Each cycle: compare at the falling edge, then advance to just past the next rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_model();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    #1 rst_n = 1'b0;
    #20;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_seconds", 32'(seconds), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_minute_en", 32'(minute_en), 0);
    chk("rst_minutes_clr", 32'(minutes_clr), 0);
    cyc(20);
    chk("idle_seconds", 32'(seconds), 0);

    // full minute
    start = 1; cyc(1); start = 0;
    chk("run_entry_running", 32'(running), 1);
    chk("run_entry_seconds", 32'(seconds), 0);
    cyc(4);
    chk("first_tick_seconds", 32'(seconds), 1);
    cyc(235);
    chk("pre_wrap_seconds", 32'(seconds), 59);
    chk("pre_wrap_minute_en", 32'(minute_en), 1);
    cyc(1);
    chk("wrap_seconds", 32'(seconds), 0);
    chk("wrap_minute_en", 32'(minute_en), 0);
    clear = 1; cyc(1); clear = 0;
    chk("clr_pulse", 32'(minutes_clr), 1);
    cyc(1);
    chk("clr_pulse_end", 32'(minutes_clr), 0);

    // pause and resume with partial prescale
    start = 1; cyc(1); start = 0;
    cyc(6);
    chk("partial_seconds", 32'(seconds), 1);
    stop = 1; cyc(1); stop = 0;
    chk("pause_running", 32'(running), 0);
    cyc(20);
    chk("pause_seconds", 32'(seconds), 1);
    start = 1; cyc(1); start = 0;
    chk("resume_running", 32'(running), 1);
    cyc(1);
    chk("resume_1_seconds", 32'(seconds), 1);
    cyc(1);
    chk("resume_2_seconds", 32'(seconds), 2);

    // clear beats start
    cyc(140);
    chk("at_37_seconds", 32'(seconds), 37);
    clear = 1; start = 1; cyc(1); clear = 0; start = 0;
    chk("clr37_seconds", 32'(seconds), 0);
    chk("clr37_running", 32'(running), 0);
    chk("clr37_minutes_clr", 32'(minutes_clr), 1);
    cyc(1);
    chk("clr37_minutes_clr_end", 32'(minutes_clr), 0);
    cyc(8);
    chk("clr37_idle", 32'(running), 0);

    // held start, then stop+start together on the tick cycle
    start = 1; cyc(1);
    cyc(49);
    chk("held_running", 32'(running), 1);
    chk("held_seconds", 32'(seconds), 12);
    start = 0; cyc(2);
    stop = 1; start = 1; cyc(1); stop = 0; start = 0;
    chk("pair_running", 32'(running), 0);
    chk("pair_seconds", 32'(seconds), 12);
    cyc(3);
    start = 1; cyc(1); start = 0;
    chk("pair_resume_seconds", 32'(seconds), 12);
    cyc(1);
    chk("pair_resume_tick", 32'(seconds), 13);
    clear = 1; cyc(1); clear = 0;
    cyc(2);

    // async reset at the wrap cycle
    start = 1; cyc(1); start = 0;
    cyc(239);
    chk("arst_pre_seconds", 32'(seconds), 59);
    chk("arst_pre_minute_en", 32'(minute_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seconds", 32'(seconds), 0);
    chk("arst_running", 32'(running), 0);
    chk("arst_minute_en", 32'(minute_en), 0);
    chk("arst_minutes_clr", 32'(minutes_clr), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(5);
    chk("post_arst_running", 32'(running), 0);
    chk("post_arst_seconds", 32'(seconds), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
